// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ALU writeback slice.
//   - default register-file word/address widths
//   - 3-bit ALU opcode constants
//   - writeback FSM state type
package alu_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned ADDR_W_DEF = 4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_MUL = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_DIV = 3'b100;
   localparam logic [2:0] OP_GT  = 3'b101;
   localparam logic [2:0] OP_LT  = 3'b110;
   localparam logic [2:0] OP_SHL = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2
   } wb_state_t;

endpackage

// File: rtl/alu_writeback.sv
// alu_writeback: takes ALU results over a valid/ready handshake and writes
// them into the register file. Mul results are double-width and take two
// writes (low half to rd, high half to rd+1 with wrap). Compare ops update
// the architectural flag register.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid / in_ready         result handshake
//   alu_op, d_out, rd           opcode, 2*DATA_W result, destination register
//   z_flag, a_grt_b, b_grt_a    ALU compare flags
//   wr_en, wr_addr, wr_data     register-file write port
//   flag_z, flag_gt, flag_lt    architectural flag register
//   wb_done                     pulse on the last write of an op
module alu_writeback
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            alu_op,
   input  logic [2*DATA_W-1:0]   d_out,
   input  logic [ADDR_W-1:0]     rd,
   input  logic                  z_flag,
   input  logic                  a_grt_b,
   input  logic                  b_grt_a,
   output logic                  wr_en,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [DATA_W-1:0]     wr_data,
   output logic                  flag_z,
   output logic                  flag_gt,
   output logic                  flag_lt,
   output logic                  wb_done
);

   wb_state_t             state, next_state;
   logic [2:0]            cap_op;
   logic [2*DATA_W-1:0]   cap_data;
   logic [ADDR_W-1:0]     cap_rd;
   logic                  cap_z, cap_gt, cap_lt;
   logic                  accept;
   logic                  cap_is_mul;

   assign cap_is_mul = (cap_op == OP_MUL);
   assign accept     = in_valid && in_ready;

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (accept) next_state = WR_LO;
         end
         WR_LO: begin
            in_ready = !cap_is_mul;
            if (cap_is_mul)  next_state = WR_HI;
            else if (accept) next_state = WR_LO;
            else             next_state = IDLE;
         end
         WR_HI:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_op   <= '0;
         cap_data <= '0;
         cap_rd   <= '0;
         cap_z    <= 1'b0;
         cap_gt   <= 1'b0;
         cap_lt   <= 1'b0;
      end else if (accept) begin
         cap_op   <= alu_op;
         cap_data <= d_out;
         cap_rd   <= rd;
         cap_z    <= z_flag;
         cap_gt   <= a_grt_b;
         cap_lt   <= b_grt_a;
      end
   end

   // Write-port outputs are registered so they line up with the state that
   // is entered on the same edge: an accept loads the low-half write directly
   // from the inputs, and the WR_LO of a mul loads the high-half write from
   // the capture registers. Address/data hold when no write follows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         wb_done <= 1'b0;
      end else if (accept) begin
         wr_en   <= 1'b1;
         wr_addr <= rd;
         wr_data <= d_out[DATA_W-1:0];
         wb_done <= (alu_op != OP_MUL);
      end else if (state == WR_LO && cap_is_mul) begin
         wr_en   <= 1'b1;
         wr_addr <= cap_rd + ADDR_W'(1);
         wr_data <= cap_data[2*DATA_W-1:DATA_W];
         wb_done <= 1'b1;
      end else begin
         wr_en   <= 1'b0;
         wb_done <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_z  <= 1'b0;
         flag_gt <= 1'b0;
         flag_lt <= 1'b0;
      end else if (state == WR_LO && (cap_op == OP_GT || cap_op == OP_LT)) begin
         flag_z  <= cap_z;
         flag_gt <= cap_gt;
         flag_lt <= cap_lt;
      end
   end

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed and random stimulus for alu_writeback, checked
// against a cycle-level schedule of expected register-file writes.
module tb_alu_writeback;

   localparam int DW = 16;
   localparam int AW = 4;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      alu_op;
   logic [2*DW-1:0] d_out;
   logic [AW-1:0]   rd;
   logic            z_flag, a_grt_b, b_grt_a;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic            flag_z, flag_gt, flag_lt;
   logic            wb_done;

   alu_writeback #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .alu_op   (alu_op),
      .d_out    (d_out),
      .rd       (rd),
      .z_flag   (z_flag),
      .a_grt_b  (a_grt_b),
      .b_grt_a  (b_grt_a),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .flag_z   (flag_z),
      .flag_gt  (flag_gt),
      .flag_lt  (flag_lt),
      .wb_done  (wb_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One entry per cycle in which a register write is expected.
   typedef struct {
      int addr;
      int data;
      bit done;
      bit busy;   // stage refuses new results during this cycle
      bit fupd;   // flag register loads at the end of this cycle
      bit z, gt, lt;
   } wr_t;

   wr_t sched[$];
   int  last_addr, last_data;
   bit  m_z, m_gt, m_lt;
   int  n_assert, n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s @%0t: observed 0x%0h expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_outputs();
      bit exp_wen, exp_done, exp_ready;
      if (sched.size() > 0) begin
         exp_wen   = 1'b1;
         last_addr = sched[0].addr;
         last_data = sched[0].data;
         exp_done  = sched[0].done;
         exp_ready = !sched[0].busy;
      end else begin
         exp_wen   = 1'b0;
         exp_done  = 1'b0;
         exp_ready = 1'b1;
      end
      chk("wr_en",    32'(wr_en),    32'(exp_wen));
      chk("wr_addr",  32'(wr_addr),  32'(last_addr));
      chk("wr_data",  32'(wr_data),  32'(last_data));
      chk("wb_done",  32'(wb_done),  32'(exp_done));
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("flag_z",   32'(flag_z),   32'(m_z));
      chk("flag_gt",  32'(flag_gt),  32'(m_gt));
      chk("flag_lt",  32'(flag_lt),  32'(m_lt));
   endtask

   // Called just after a falling edge: check this cycle, drive inputs, then
   // advance the model across the coming rising edge.
   task automatic step(input bit v, input int op, input logic [31:0] d,
                       input int r, input bit z, input bit gt, input bit lt);
      bit ready_now;
      wr_t e;
      check_outputs();
      ready_now = (sched.size() == 0) || !sched[0].busy;
      in_valid = v;
      alu_op   = 3'(op);
      d_out    = d;
      rd       = 4'(r);
      z_flag   = z;
      a_grt_b  = gt;
      b_grt_a  = lt;
      if (sched.size() > 0) begin
         if (sched[0].fupd) begin
            m_z = sched[0].z; m_gt = sched[0].gt; m_lt = sched[0].lt;
         end
         void'(sched.pop_front());
      end
      if (v && ready_now) begin
         e = '{addr: r, data: int'(d[15:0]), done: (op != 1), busy: (op == 1),
               fupd: (op == 5 || op == 6), z: z, gt: gt, lt: lt};
         sched.push_back(e);
         if (op == 1) begin
            e = '{addr: (r + 1) % 16, data: int'(d[31:16]), done: 1'b1, busy: 1'b1,
                  fupd: 1'b0, z: 1'b0, gt: 1'b0, lt: 1'b0};
            sched.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 32'h0, 0, 0, 0, 0);
   endtask

   initial begin
      n_assert = 0; n_fail = 0;
      last_addr = 0; last_data = 0;
      m_z = 0; m_gt = 0; m_lt = 0;
      rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; d_out = '0; rd = '0;
      z_flag = 1'b0; a_grt_b = 1'b0; b_grt_a = 1'b0;

      // outputs during reset
      #2 check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // add on the first edge after reset release
      step(1, 0, 32'h0000_1234, 3, 0, 0, 0);
      idle();

      // mul with rd wrap 15 -> 0
      step(1, 1, 32'hABCD_0123, 15, 0, 0, 0);
      idle();
      idle();
      idle();

      // back-to-back or, and
      step(1, 3, 32'h0000_00F0, 1, 0, 0, 0);
      step(1, 2, 32'h0000_000F, 2, 0, 0, 0);
      idle();

      // compare then add: add must leave flags alone
      step(1, 5, 32'h0000_0001, 5, 0, 1, 0);
      step(1, 0, 32'h0000_7777, 6, 1, 0, 1);
      idle();
      idle();

      // stall: in_valid held through the mul, add goes in afterwards
      step(1, 1, 32'h1111_2222, 7, 0, 0, 0);
      step(1, 0, 32'h0000_3333, 8, 0, 0, 0);
      step(1, 0, 32'h0000_3333, 8, 0, 0, 0);
      step(1, 0, 32'h0000_3333, 8, 0, 0, 0);
      idle();

      // reset pulsed during WR_LO of a mul: high half is dropped
      step(1, 6, 32'h0000_0000, 4, 1, 0, 1);
      step(1, 1, 32'h5555_AAAA, 9, 0, 0, 0);
      #1 rst_n = 1'b0;
      in_valid = 1'b0;
      sched.delete();
      last_addr = 0; last_data = 0;
      m_z = 0; m_gt = 0; m_lt = 0;
      #1 check_outputs();
      #1 rst_n = 1'b1;
      idle();
      idle();

      // random traffic
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)), 32'($urandom),
              int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      idle();
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DATA_W, default 16, the register-file word width.
REQ-002 Parameter ADDR_W, default 4, the register-file address width (16 registers).
REQ-003 The block SHALL have these ports:
- clk  in  1  single rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  ALU result present.
- in_ready  out  1  stage can accept a result.
- alu_op  in  3  opcode of the result: 000 add, 001 mul, 010 and, 011 or, 100 div, 101 gt, 110 lt, 111 shl.
- d_out  in  2*DATA_W  ALU result.
- rd  in  ADDR_W  destination register.
- z_flag, a_grt_b, b_grt_a  in  1 each  ALU compare flags.
- wr_en  out  1  register-file write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- flag_z, flag_gt, flag_lt  out  1 each  architectural flag register.
- wb_done  out  1  one-cycle pulse on the last write of an op.

Function
REQ-004 Handshake SHALL be: accept when in_valid && in_ready on a rising clk edge; capture alu_op, d_out, rd and the three flags.
REQ-005 in_valid SHALL be ignored while in_ready is 0; inputs need not be held.
REQ-006 The FSM SHALL have states IDLE, WR_LO and WR_HI.
REQ-007 FSM transitions:
- IDLE -> WR_LO on accept.
- WR_LO -> WR_HI if the captured op is mul.
- WR_LO -> WR_LO on a new accept when the captured op is not mul.
- WR_LO -> IDLE when the captured op is not mul and there is no new accept.
- WR_HI -> IDLE.
REQ-008 in_ready SHALL be a combinational 1 in IDLE, and in WR_LO when the captured op is not mul; it SHALL be 0 otherwise.
REQ-009 In WR_LO the block SHALL drive wr_en=1, wr_addr=rd, wr_data=d_out[DATA_W-1:0].
REQ-010 In WR_HI the block SHALL drive wr_en=1, wr_addr=rd+1 (modulo 2^ADDR_W, so 15 wraps to 0), wr_data=d_out[2*DATA_W-1:DATA_W].
REQ-011 wr_en SHALL be 0 in IDLE; wr_addr and wr_data SHALL hold their last values there.
REQ-012 Latency: an accept in cycle N SHALL produce the write in N+1; for mul, the high-half write SHALL follow in N+2.
REQ-013 Throughput SHALL be one non-mul op per cycle; mul SHALL occupy two cycles.
REQ-014 wb_done SHALL be 1 in WR_LO for non-mul ops and in WR_HI for mul, and 0 otherwise.
REQ-015 For ops 101/110, in the WR_LO cycle, flag_z/flag_gt/flag_lt SHALL register the captured z_flag/a_grt_b/b_grt_a.
REQ-016 For all other ops, the flag registers SHALL hold their value.
REQ-017 Flag outputs SHALL be registered: they change on the clk edge that ends the WR_LO cycle.
REQ-018 Captured data SHALL be treated as opaque; the block SHALL do no arithmetic other than the rd+1 wrap.

Reset
REQ-019 While rst_n=0, the block SHALL hold:
- state = IDLE.
- wr_en = 0; wr_addr = 0; wr_data = 0.
- flag_z, flag_gt, flag_lt = 0.
- wb_done = 0.
- capture registers = 0.
- in_ready = 1.
REQ-020 Reset assertion SHALL take effect immediately, without waiting for clk.
REQ-021 Reset asserted during WR_LO/WR_HI SHALL abort the op; the pending high-half write SHALL be lost and SHALL NOT be replayed.
REQ-022 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-023 A shared package alu_pkg SHALL hold:
- the 3-bit opcode constants (OP_ADD..OP_SHL);
- the state encoding typedef (IDLE, WR_LO, WR_HI);
- DATA_W and ADDR_W defaults.
REQ-024 The block SHALL be a single module with no sub-module; the flag register SHALL be inline.

Verification
REQ-025 Reset then add: alu_op=000, d_out=0x0000_1234, rd=3 -> next cycle wr_en=1, wr_addr=3, wr_data=0x1234, wb_done=1; flags stay 0.
REQ-026 Mul at wrap: alu_op=001, d_out=0xABCD_0123, rd=15 -> cycle N+1 writes 0x0123 to r15 with in_ready=0; cycle N+2 writes 0xABCD to r0 with wb_done=1.
REQ-027 Back-to-back: or to rd=1, then and to rd=2, on consecutive cycles with in_valid held -> writes on two consecutive cycles with no bubble; in_ready stays 1.
REQ-028 Compare: alu_op=101, d_out=1, a_grt_b=1 -> r[rd]=0x0001; flag_gt=1, flag_lt=0, flag_z=0 after WR_LO; a following add leaves the flags unchanged.
REQ-029 Mid-op reset: rst_n pulsed low during the WR_LO of a mul -> no WR_HI write; all outputs 0; in_ready=1 immediately.
REQ-030 Stall: in_valid=1 during WR_HI of a mul -> no accept that cycle; the op is accepted the next cycle and written at N+1.
